sequenciador_exibicao: RTL
==========================

// Module: sequenciador_exibicao
// PURPOSE
//  Plays back the stored round sequence on the 8 game LEDs before the player's turn.
//  Started by the main control unit with a one-cycle pulse.
//  Walks the sequence memory from address 0 up to the round limit.
//  For each entry: lights its LED pattern for T_ON cycles, then blanks for T_OFF cycles.
//  Signals completion with a one-cycle pronto pulse.
//  Timing (easy/hard) is chosen by the dificuldade switch, which is latched at start.
// PARAMETERS
//  ADDR_W        4     sequence memory address width (depth 2**ADDR_W)
//  LED_W         8     LED / memory data width
//  CNT_W         16    timer counter width; every T_* value must be < 2**CNT_W
//  T_ON_FACIL    1000  LED-on cycles, dificuldade=0 (must be >= 1)
//  T_OFF_FACIL   500   LED-off cycles, dificuldade=0 (must be >= 1)
//  T_ON_DIFICIL  500   LED-on cycles, dificuldade=1 (must be >= 1)
//  T_OFF_DIFICIL 250   LED-off cycles, dificuldade=1 (must be >= 1)
// PORTS
//  clock         in   1       system clock, rising edge
//  reset         in   1       asynchronous reset, active-low
//  iniciar       in   1       start pulse; honoured only in OCIOSO
//  abortar       in   1       synchronous abort; returns to OCIOSO without pronto
//  dificuldade   in   1       0=easy, 1=hard; sampled when start is accepted
//  limite        in   ADDR_W  address of last entry to show; sampled at start
//  mem_dado      in   LED_W   sequence memory read data
//                             (synchronous memory: valid one cycle after mem_endereco changes)
//  mem_endereco  out  ADDR_W  sequence memory read address (registered)
//  leds          out  LED_W   LED drive (registered)
//  exibindo      out  1       high in every state except OCIOSO and FIM
//  pronto        out  1       one-cycle pulse after the last entry's off time
//  db_estado     out  4       current state code, for hexa7seg debug display
// BEHAVIOUR
//  Reset (reset=0, asynchronous):
//   - state=OCIOSO; mem_endereco=0; leds=0; timer=0.
//   - Internal registers: limite_reg=0, dif_reg=0.
//   - Outputs: exibindo=0, pronto=0.
//  States and codes:
//   - OCIOSO=0, CARREGA=1, ACENDE=2, APAGA=3, FIM=4.
//  OCIOSO:
//   - On iniciar=1: latch limite->limite_reg and dificuldade->dif_reg.
//   - Set mem_endereco=0; go to CARREGA.
//  CARREGA (1 cycle):
//   - Memory data is settling.
//   - At end of cycle: leds<=mem_dado, timer<=0; go to ACENDE.
//  ACENDE (T_ON cycles; T_ON selected by dif_reg):
//   - leds holds the pattern; timer increments each cycle.
//   - When timer==T_ON-1: leds<=0, timer<=0; go to APAGA.
//  APAGA (T_OFF cycles; T_OFF selected by dif_reg):
//   - When timer==T_OFF-1 and mem_endereco==limite_reg: go to FIM.
//   - When timer==T_OFF-1 otherwise: mem_endereco+1; go to CARREGA.
//  FIM (1 cycle):
//   - pronto=1; go to OCIOSO.
//  Latency:
//   - iniciar accepted in cycle k, N = limite+1 entries.
//   - Entry i is lit in cycles k+2+i*(1+T_ON+T_OFF) .. k+1+T_ON+i*(1+T_ON+T_OFF).
//   - pronto is high in cycle k+1+N*(1+T_ON+T_OFF).
//  Boundaries:
//   - iniciar outside OCIOSO is ignored; this includes the FIM cycle.
//   - dificuldade and limite changes during playback have no effect.
//   - limite = 2**ADDR_W-1: the full memory is shown; mem_endereco never wraps to 0.
//   - abortar has priority over every transition, including iniciar in the same cycle.
//     Next cycle: OCIOSO, leds=0, pronto=0, mem_endereco held.
//   - Reset mid-playback clears everything immediately, without waiting for a clock edge.
//   - mem_dado is shown unmodified; a non-one-hot or all-zero pattern is legal.
// TESTING
//  Bench parameters: T_ON_FACIL=4, T_OFF_FACIL=2, T_ON_DIFICIL=2, T_OFF_DIFICIL=1.
//  T1: limite=0, dif=0, mem[0]=8'h01, iniciar at k
//      -> leds=8'h01 in k+2..k+5; leds=0 in k+6..k+7; pronto only at k+8.
//  T2: limite=3, dif=1, mem={01,02,04,08}
//      -> mem_endereco steps 0,1,2,3; each pattern lit 2 cycles; pronto at k+17.
//  T3: limite=15, dif=1
//      -> 16 entries shown; mem_endereco stops at 15; pronto at k+65; no wrap to 0.
//  T4: during T2, pulse iniciar and toggle dificuldade at k+5
//      -> timing and pronto identical to T2.
//  T5: abortar at k+3 (ACENDE) -> k+4: db_estado=0, leds=0, exibindo=0; no pronto ever.
//      Separately, reset=0 mid-APAGA -> leds=0 and state=0 immediately.
//  T6: iniciar and abortar both high in OCIOSO -> stays OCIOSO, exibindo=0.

Source files
------------

// File: rtl/sequenciador_exibicao.sv
// Plays the stored round sequence on the game LEDs: each entry is lit for T_ON
// cycles and then blanked for T_OFF cycles, and pronto pulses once at the end.
module sequenciador_exibicao #(
   parameter int ADDR_W        = 4,
   parameter int LED_W         = 8,
   parameter int CNT_W         = 16,
   parameter int T_ON_FACIL    = 1000,
   parameter int T_OFF_FACIL   = 500,
   parameter int T_ON_DIFICIL  = 500,
   parameter int T_OFF_DIFICIL = 250
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              iniciar,
   input  logic              abortar,
   input  logic              dificuldade,
   input  logic [ADDR_W-1:0] limite,
   input  logic [LED_W-1:0]  mem_dado,
   output logic [ADDR_W-1:0] mem_endereco,
   output logic [LED_W-1:0]  leds,
   output logic              exibindo,
   output logic              pronto,
   output logic [3:0]        db_estado
);

   typedef enum logic [2:0] {
      OCIOSO  = 3'd0,
      CARREGA = 3'd1,
      ACENDE  = 3'd2,
      APAGA   = 3'd3,
      FIM     = 3'd4
   } estado_t;

   estado_t           estado, prox_estado;
   logic [CNT_W-1:0]  timer, prox_timer;
   logic [CNT_W-1:0]  t_on_fim, t_off_fim;
   logic [ADDR_W-1:0] prox_endereco, limite_reg, prox_limite;
   logic [LED_W-1:0]  prox_leds;
   logic              dif_reg, prox_dif;

   // Terminal counts come from the difficulty latched at start, not the live switch.
   assign t_on_fim  = dif_reg ? CNT_W'(T_ON_DIFICIL - 1)  : CNT_W'(T_ON_FACIL - 1);
   assign t_off_fim = dif_reg ? CNT_W'(T_OFF_DIFICIL - 1) : CNT_W'(T_OFF_FACIL - 1);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado       <= OCIOSO;
         timer        <= '0;
         mem_endereco <= '0;
         leds         <= '0;
         limite_reg   <= '0;
         dif_reg      <= 1'b0;
      end else begin
         estado       <= prox_estado;
         timer        <= prox_timer;
         mem_endereco <= prox_endereco;
         leds         <= prox_leds;
         limite_reg   <= prox_limite;
         dif_reg      <= prox_dif;
      end
   end

   always_comb begin
      prox_estado   = estado;
      prox_timer    = timer;
      prox_endereco = mem_endereco;
      prox_leds     = leds;
      prox_limite   = limite_reg;
      prox_dif      = dif_reg;

      case (estado)
         OCIOSO: begin
            if (iniciar) begin
               prox_limite   = limite;
               prox_dif      = dificuldade;
               prox_endereco = '0;
               prox_estado   = CARREGA;
            end
         end
         CARREGA: begin
            prox_leds   = mem_dado;
            prox_timer  = '0;
            prox_estado = ACENDE;
         end
         ACENDE: begin
            if (timer == t_on_fim) begin
               prox_leds   = '0;
               prox_timer  = '0;
               prox_estado = APAGA;
            end else begin
               prox_timer = timer + CNT_W'(1);
            end
         end
         APAGA: begin
            if (timer == t_off_fim) begin
               prox_timer = '0;
               // Stopping on equality keeps a full-depth limit from wrapping to 0.
               if (mem_endereco == limite_reg) begin
                  prox_estado = FIM;
               end else begin
                  prox_endereco = mem_endereco + ADDR_W'(1);
                  prox_estado   = CARREGA;
               end
            end else begin
               prox_timer = timer + CNT_W'(1);
            end
         end
         FIM: begin
            prox_estado = OCIOSO;
         end
         default: begin
            prox_estado = OCIOSO;
         end
      endcase

      // Abort overrides everything above, including a start in the same cycle.
      if (abortar) begin
         prox_estado   = OCIOSO;
         prox_leds     = '0;
         prox_timer    = '0;
         prox_endereco = mem_endereco;
         prox_limite   = limite_reg;
         prox_dif      = dif_reg;
      end
   end

   assign exibindo  = (estado != OCIOSO) && (estado != FIM);
   assign pronto    = (estado == FIM);
   assign db_estado = {1'b0, estado};

endmodule
